add_datapath: RTL and testbench

ADD_DATAPATH -- requirements
Module: add_datapath

---
 rtl/add_datapath.sv | 129 ++++++++++++
 tb/tb_add_datapath.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/add_datapath.sv
`default_nettype none
// ============================================================================
// Module      : add_datapath
// Description : Two operand registers feeding a (WIDTH+1)-bit adder. Each
//               result {sum,cout,ovf} is queued in a 2-entry FIFO drained
//               with a valid/ready handshake. A push into a full FIFO with
//               no pop is dropped and sets a sticky error flag.
// Revision    : 1.0 - initial release
// ============================================================================
module add_datapath #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             lda,
  input  logic             ldb,
  input  logic             ldc,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             res_valid,
  input  logic             res_ready,
  output logic             drop_err,
  output logic [7:0]       op_count
);

  // One FIFO entry: {sum, cout, ovf}
  localparam int ENTRY_W = WIDTH + 2;

  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [ENTRY_W-1:0] mem_q [2];
  logic [ENTRY_W-1:0] mem_d [2];
  logic               rd_ptr_q, rd_ptr_d;
  logic               wr_ptr_q, wr_ptr_d;
  logic [1:0]         count_q, count_d;
  logic               drop_q, drop_d;
  logic [7:0]         opcnt_q, opcnt_d;

  logic [WIDTH:0]     w_add;
  logic               w_ovf;
  logic [ENTRY_W-1:0] w_entry;
  logic               w_full;
  logic               w_pop;
  logic               w_push;
  logic [ENTRY_W-1:0] w_head;

  // Adder and overflow from the register values held before this edge
  always_comb begin
    w_add   = {1'b0, a_q} + {1'b0, b_q};
    w_ovf   = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (w_add[WIDTH-1] != a_q[WIDTH-1]);
    w_entry = {w_add[WIDTH-1:0], w_add[WIDTH], w_ovf};
  end

  // FIFO handshake: a pop frees a slot for a same-cycle push when full
  always_comb begin
    w_full = (count_q == 2'd2);
    w_pop  = (count_q != 2'd0) && res_ready;
    w_push = ldc && (!w_full || w_pop);
  end

  // Next-state for operands, FIFO storage, pointers, flags and counter
  always_comb begin
    a_d      = lda ? din : a_q;
    b_d      = ldb ? din : b_q;
    mem_d[0] = mem_q[0];
    mem_d[1] = mem_q[1];
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    drop_d   = drop_q;
    opcnt_d  = opcnt_q;
    if (w_push) begin
      mem_d[wr_ptr_q] = w_entry;
      wr_ptr_d        = ~wr_ptr_q;
      opcnt_d         = opcnt_q + 8'd1;
    end
    if (w_pop) begin
      rd_ptr_d = ~rd_ptr_q;
    end
    case ({w_push, w_pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
    if (ldc && w_full && !w_pop) begin
      drop_d = 1'b1;
    end
  end

  // State registers with asynchronous clear
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q      <= '0;
      b_q      <= '0;
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      count_q  <= 2'd0;
      drop_q   <= 1'b0;
      opcnt_q  <= 8'd0;
    end else begin
      a_q      <= a_d;
      b_q      <= b_d;
      mem_q[0] <= mem_d[0];
      mem_q[1] <= mem_d[1];
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      drop_q   <= drop_d;
      opcnt_q  <= opcnt_d;
    end
  end

  // Head entry is forced to zero while the FIFO is empty
  always_comb begin
    w_head    = (count_q != 2'd0) ? mem_q[rd_ptr_q] : '0;
    sum       = w_head[ENTRY_W-1:2];
    cout      = w_head[1];
    ovf       = w_head[0];
    res_valid = (count_q != 2'd0);
    drop_err  = drop_q;
    op_count  = opcnt_q;
  end

endmodule
`default_nettype wire

// File: tb/tb_add_datapath.sv
`default_nettype none
// ============================================================================
// Module      : tb_add_datapath
// Description : Directed self-checking bench for add_datapath.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_add_datapath;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       lda = 1'b0;
  logic       ldb = 1'b0;
  logic       ldc = 1'b0;
  logic [7:0] din = 8'h00;
  logic [7:0] sum;
  logic       cout;
  logic       ovf;
  logic       res_valid;
  logic       res_ready = 1'b0;
  logic       drop_err;
  logic [7:0] op_count;

  int checks = 0;
  int errors = 0;

  add_datapath #(.WIDTH(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .lda       (lda),
    .ldb       (ldb),
    .ldc       (ldc),
    .din       (din),
    .sum       (sum),
    .cout      (cout),
    .ovf       (ovf),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .drop_err  (drop_err),
    .op_count  (op_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_a(input logic [7:0] v);
    lda = 1'b1; din = v; tick(); lda = 1'b0;
  endtask

  task automatic load_b(input logic [7:0] v);
    ldb = 1'b1; din = v; tick(); ldb = 1'b0;
  endtask

  task automatic compute();
    ldc = 1'b1; tick(); ldc = 1'b0;
  endtask

  initial begin
    // Reset state while rst held high
    #2;
    chk("rst_valid", res_valid, 0);
    chk("rst_sum", sum, 0);
    chk("rst_cout", cout, 0);
    chk("rst_ovf", ovf, 0);
    chk("rst_drop", drop_err, 0);
    chk("rst_opcnt", op_count, 0);
    tick();
    rst = 1'b0;
    tick();

    // Basic add 5+3, then popped
    res_ready = 1'b1;
    load_a(8'h05);
    load_b(8'h03);
    compute();
    chk("add_valid", res_valid, 1);
    chk("add_sum", sum, 8'h08);
    chk("add_cout", cout, 0);
    chk("add_ovf", ovf, 0);
    tick();
    chk("add_empty", res_valid, 0);
    chk("add_empty_sum", sum, 0);
    chk("add_opcnt", op_count, 1);

    // Carry out: FF+01
    load_a(8'hFF);
    load_b(8'h01);
    compute();
    chk("carry_sum", sum, 8'h00);
    chk("carry_cout", cout, 1);
    chk("carry_ovf", ovf, 0);
    tick();
    // Signed overflow: 7F+01
    load_a(8'h7F);
    compute();
    chk("ovf_sum", sum, 8'h80);
    chk("ovf_cout", cout, 0);
    chk("ovf_ovf", ovf, 1);
    tick();
    chk("ovf_opcnt", op_count, 3);

    // Full FIFO with simultaneous push and pop: no drop
    res_ready = 1'b0;
    load_a(8'h00);
    load_b(8'h04);
    compute();
    load_b(8'h05);
    compute();
    chk("full_head", sum, 8'h04);
    load_b(8'h06);
    ldc = 1'b1; res_ready = 1'b1; tick(); ldc = 1'b0; res_ready = 1'b0;
    chk("pp_drop", drop_err, 0);
    chk("pp_opcnt", op_count, 6);
    chk("pp_head", sum, 8'h05);
    res_ready = 1'b1;
    tick();
    chk("pp_valid2", res_valid, 1);
    chk("pp_head2", sum, 8'h06);
    tick();
    chk("pp_empty", res_valid, 0);

    // Drop on full: sums 1,2,3 with no consumer
    res_ready = 1'b0;
    load_b(8'h01);
    compute();
    load_b(8'h02);
    compute();
    load_b(8'h03);
    compute();
    chk("drop_err", drop_err, 1);
    chk("drop_opcnt", op_count, 8);
    chk("drop_head1", sum, 8'h01);
    res_ready = 1'b1;
    tick();
    chk("drop_head2", sum, 8'h02);
    chk("drop_valid2", res_valid, 1);
    tick();
    chk("drop_empty", res_valid, 0);
    chk("drop_sticky", drop_err, 1);

    // Load A and compute in the same cycle uses the old A
    res_ready = 1'b0;
    load_a(8'h01);
    load_b(8'h02);
    lda = 1'b1; din = 8'h10; ldc = 1'b1; tick(); lda = 1'b0; ldc = 1'b0;
    chk("same_sum", sum, 8'h03);
    compute();
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    chk("same_sum2", sum, 8'h12);
    compute();
    chk("pre_rst_opcnt", op_count, 11);

    // Asynchronous reset between edges with two entries buffered
    #2 rst = 1'b1;
    #1;
    chk("arst_valid", res_valid, 0);
    chk("arst_opcnt", op_count, 0);
    chk("arst_drop", drop_err, 0);
    chk("arst_sum", sum, 0);
    #1 rst = 1'b0;
    compute();
    chk("post_rst_sum", sum, 8'h00);
    chk("post_rst_valid", res_valid, 1);
    chk("post_rst_opcnt", op_count, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
